// File: rtl/hpdcache_core_credit_arbiter_pkg.sv
// Shared types and helpers for the HPDcache core-side credit arbiter.
package hpdcache_core_credit_arbiter_pkg;

  // Default source-ID width used by the HPDcache request/response path.
  localparam int unsigned HPDCACHE_REQ_SID_W = 3;
  typedef logic [HPDCACHE_REQ_SID_W-1:0] hpdcache_req_sid_t;

  // Arbiter grant state: open for arbitration, or holding a stalled grant.
  typedef enum logic {
    ARB_OPEN = 1'b0,
    ARB_HELD = 1'b1
  } arb_state_e;

  // Index of the first set bit of req at or above ptr, wrapping modulo n.
  // Returns -1 when no bit below n is set. Expects ptr < n <= 32.
  function automatic int hpdcache_rr_first(input logic [31:0] req,
                                           input int unsigned ptr,
                                           input int unsigned n);
    int          win;
    int unsigned idx;
    win = -1;
    for (int unsigned k = 0; k < 32; k++) begin
      idx = ptr + k;
      if (idx >= n) begin
        idx = idx - n;
      end else begin
        idx = idx;
      end
      if ((k < n) && (win < 0) && req[idx[4:0]]) begin
        win = int'(idx);
      end else begin
        win = win;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/hpdcache_core_credit_arbiter_rrarb.sv
// Round-robin arbiter that holds its grant while the downstream stalls.
module hpdcache_core_credit_arbiter_rrarb
  import hpdcache_core_credit_arbiter_pkg::*;
#(
  parameter  int unsigned N     = 4,
  localparam int unsigned PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [N-1:0] valid_i,
  input  logic [N-1:0] elig_i,
  input  logic         ready_i,
  output logic [N-1:0] gnt_o,
  output logic         accept_o
);

  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(N - 1);

  arb_state_e       state_q, state_d;
  logic [N-1:0]     gnt_held_q, gnt_held_d;
  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [N-1:0]     gnt_arb;
  logic [PTR_W-1:0] gnt_idx;
  logic             hold;
  int               win;

  // Fresh round-robin pick, overridden by the held grant while its owner stays valid.
  always_comb begin
    win     = hpdcache_rr_first(32'(elig_i), 32'(rr_ptr_q), N);
    gnt_arb = {N{1'b0}};
    for (int i = 0; i < int'(N); i++) begin
      gnt_arb[i] = (win == i);
    end
    hold = (state_q == ARB_HELD) && (|(gnt_held_q & valid_i));
    if (hold) begin
      gnt_o = gnt_held_q;
    end else begin
      gnt_o = gnt_arb;
    end
  end

  assign accept_o = (|gnt_o) & ready_i;

  // Next pointer just past the accepted requester; hold the grant on a stall.
  always_comb begin
    gnt_idx = {PTR_W{1'b0}};
    for (int i = 0; i < int'(N); i++) begin
      if (gnt_o[i]) begin
        gnt_idx = PTR_W'(i);
      end else begin
        gnt_idx = gnt_idx;
      end
    end
    rr_ptr_d = rr_ptr_q;
    if (accept_o) begin
      if (gnt_idx == LAST_IDX) begin
        rr_ptr_d = {PTR_W{1'b0}};
      end else begin
        rr_ptr_d = gnt_idx + PTR_W'(1);
      end
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
    case ({|gnt_o, ready_i})
      2'b10: begin
        state_d    = ARB_HELD;
        gnt_held_d = gnt_o;
      end
      default: begin
        state_d    = ARB_OPEN;
        gnt_held_d = {N{1'b0}};
      end
    endcase
  end

  // Arbitration state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ARB_OPEN;
      gnt_held_q <= {N{1'b0}};
      rr_ptr_q   <= {PTR_W{1'b0}};
    end else begin
      state_q    <= state_d;
      gnt_held_q <= gnt_held_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

endmodule

// File: rtl/hpdcache_core_credit_arbiter.sv
// Core-request arbiter for the HPDcache with per-requester outstanding credits.
module hpdcache_core_credit_arbiter
  import hpdcache_core_credit_arbiter_pkg::*;
#(
  parameter  int unsigned N_REQ           = 4,
  parameter  int unsigned MAX_OUTSTANDING = 4,
  parameter  int unsigned SID_WIDTH       = 3,
  localparam int unsigned CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [N_REQ-1:0]         req_valid_i,
  input  logic [N_REQ-1:0]         req_need_rsp_i,
  output logic [N_REQ-1:0]         req_ready_o,
  input  logic [N_REQ-1:0]         req_abort_i,
  output logic                     arb_req_valid_o,
  input  logic                     arb_req_ready_i,
  output logic [N_REQ-1:0]         arb_gnt_o,
  output logic [N_REQ-1:0]         arb_gnt_q_o,
  input  logic                     rsp_valid_i,
  input  logic [SID_WIDTH-1:0]     rsp_sid_i,
  output logic [N_REQ*CNT_W-1:0]   outstanding_o,
  output logic                     err_underflow_o
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

  logic [N_REQ-1:0] elig;
  logic [N_REQ-1:0] gnt;
  logic             accept;
  logic [N_REQ-1:0] gnt_q_q;
  logic             need_q;
  logic [N_REQ-1:0] underflow;
  logic             err_q;

  hpdcache_core_credit_arbiter_rrarb #(
    .N (N_REQ)
  ) u_rrarb (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .valid_i  (req_valid_i),
    .elig_i   (elig),
    .ready_i  (arb_req_ready_i),
    .gnt_o    (gnt),
    .accept_o (accept)
  );

  assign arb_gnt_o       = gnt;
  assign arb_req_valid_o = |gnt;
  assign req_ready_o     = gnt & {N_REQ{arb_req_ready_i}};
  assign arb_gnt_q_o     = gnt_q_q;
  assign err_underflow_o = err_q;

  // Second-cycle select and whether that accepted request holds a credit.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      gnt_q_q <= {N_REQ{1'b0}};
      need_q  <= 1'b0;
    end else begin
      gnt_q_q <= gnt & {N_REQ{accept}};
      need_q  <= accept & (|(gnt & req_need_rsp_i));
    end
  end

  for (genvar i = 0; i < int'(N_REQ); i++) begin : g_cnt
    logic             inc, dec_ab, dec_rsp, uf;
    logic [CNT_W:0]   up;
    logic [1:0]       down;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign elig[i]      = req_valid_i[i] & (cnt_q < MAX_CNT);
    assign underflow[i] = uf;
    assign outstanding_o[i*CNT_W +: CNT_W] = cnt_q;

    // Net credit change; an abort or response on an empty counter saturates at zero.
    always_comb begin
      inc     = accept & gnt[i] & req_need_rsp_i[i];
      dec_ab  = gnt_q_q[i] & need_q & req_abort_i[i];
      dec_rsp = rsp_valid_i & (rsp_sid_i == SID_WIDTH'(i));
      up      = {1'b0, cnt_q} + {{CNT_W{1'b0}}, inc};
      down    = {1'b0, dec_ab} + {1'b0, dec_rsp};
      if (up < (CNT_W + 1)'(down)) begin
        cnt_d = {CNT_W{1'b0}};
        uf    = 1'b1;
      end else begin
        cnt_d = CNT_W'(up - (CNT_W + 1)'(down));
        uf    = 1'b0;
      end
    end

    // Outstanding-request counter for this requester.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        cnt_q <= {CNT_W{1'b0}};
      end else begin
        cnt_q <= cnt_d;
      end
    end
  end

  // Sticky underflow flag, cleared only by reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_q | (|underflow);
    end
  end

endmodule
